key_tone_arbiter: RTL
=====================

Name: key_tone_arbiter

Overview:
Shares one square-wave tone generator among NUM_KEYS light-sensor piano keys (C4..C5).
- Synchronises and debounces every key.
- Grants the single speaker to one pressed key using lowest-index-wins arbitration, without preemption.
- Loads the granted note's half-period into a tone-generator sub-module.
- Sits between the light-sensor inputs and the board speaker pin, and replaces the per-note sound blocks.

Parameters:
NUM_KEYS, 8, number of key inputs. Index 0 = C4 … index 7 = C5. Must not exceed the table size.
DEBOUNCE_CYC, 3, consecutive stable synchronised samples required to change a key's debounced state (>=1).
GAP_CYC, 2, silent clocks inserted after a release before re-arbitration (>=1).
CNT_W, 32, tone counter width.

Ports:
clk  in  1  system clock, 50 MHz.
rst  in  1  asynchronous, active-low reset.
key_in  in  NUM_KEYS  raw light-sensor levels, 1 = pressed, asynchronous to clk.
enable  in  1  global mute; 0 forces release of the current grant.
speaker  out  1  square-wave output.
key_valid  out  1  1 while in PLAY.
active_key  out  $clog2(NUM_KEYS)  index of the granted key; valid when key_valid = 1.

Behaviour:
- Reset (rst = 0, asynchronous, takes effect immediately, including mid-note):
  - speaker = 0, key_valid = 0, active_key = 0.
  - Synchronisers, debounced states and debounce counters = 0.
  - Tone counter = 0, gap counter = 0, FSM = IDLE.
- Synchroniser: 2 flops per key.
- Debouncer (per key):
  - Counter increments while the synchronised value differs from the debounced value; it clears when they match.
  - When the count reaches DEBOUNCE_CYC, the debounced value flips and the counter clears.
  - Raw edge to debounced edge latency is 2 + DEBOUNCE_CYC clocks.
- req[i] = debounced[i] & enable.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: speaker = 0. If any req is set, capture the lowest set index into active_key and go to LOAD. Otherwise stay.
  - LOAD (1 clock): tone counter = HALF_PERIOD[active_key] − 1, speaker = 0, then go to PLAY.
  - PLAY: key_valid = 1.
    - Counter decrements each clock. At 0 it reloads HALF_PERIOD − 1 and toggles speaker.
    - First speaker rise occurs HALF_PERIOD clocks after entering PLAY; the full period is 2·HALF_PERIOD clocks.
    - If req[active_key] = 0, go to GAP next clock and force speaker to 0 on entry.
    - Other keys pressed or released during PLAY are ignored (no preemption).
  - GAP: speaker = 0, key_valid = 0. Gap counter counts GAP_CYC clocks, then clears and the FSM goes to IDLE. Presses during GAP are honoured at IDLE.
- Simultaneous debounced presses: the lowest index wins. A higher key still held after the owner's release is granted after GAP + IDLE + LOAD.
- enable falling during PLAY behaves exactly like an owner release. enable = 0 in IDLE keeps the FSM in IDLE.
- active_key holds its last value outside PLAY.
- Counter arithmetic is unsigned CNT_W-bit. HALF_PERIOD values must be >= 2.

Decomposition:
- Package key_tone_pkg:
  - State enum.
  - HALF_PERIOD table (50 MHz): C4 95556, D4 85132, E4 75844, F4 71586, G4 63776, A4 56818, B4 50620, C5 47778.
- One sub-module, tone_gen: inputs load, half_period, run; output speaker. Contains the reload counter and toggle.
- Synchroniser and debouncer are generate loops inside the top level.

Test Plan:
- Reset then idle: key_in = 0 for 1000 clocks → speaker = 0, key_valid = 0, active_key = 0 throughout.
- Single key: key_in[2] (E4) held high → key_valid rises 2 + 3 + 1 + 1 = 7 clocks after the raw edge. Speaker first rises 75844 clocks after the PLAY entry clock, then toggles every 75844 clocks.
- Bounce rejection: key_in[0] high for 2 clocks, low 1, high 2, low → no grant; key_valid stays 0.
- Simultaneous press: keys 1 and 5 rise in the same clock → active_key = 1 (half period 85132). Release key 1 while 5 is held → speaker 0 for GAP (2 clocks), IDLE, LOAD, then active_key = 5 and half period 63776.
- Mute: PLAY on key 7, enable → 0 → next clock GAP with speaker 0, then IDLE held. enable → 1 with key 7 still held → re-grant of 7.
- Async reset mid-note: rst low while speaker = 1 in PLAY → speaker = 0 and key_valid = 0 immediately (before the next clk edge). After release, regrant needs full re-debounce (7 clocks).

Source files
------------

// File: rtl/key_tone_pkg.sv
// Shared state encoding and 50 MHz half-period table for the key tone arbiter.
// Pure declarations: no latency, no flow control.
package key_tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int TABLE_SIZE = 8;

  // C4, D4, E4, F4, G4, A4, B4, C5 in clk cycles per half wave
  localparam logic [31:0] HALF_PERIOD [TABLE_SIZE] = '{
    32'd95556, 32'd85132, 32'd75844, 32'd71586,
    32'd63776, 32'd56818, 32'd50620, 32'd47778
  };

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: reload counter toggles speaker every half_period clocks while run=1.
// First rise half_period clocks after load; no flow control, run=0 forces speaker low next clock.
module tone_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] half_period,
  output logic             speaker
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (load) begin
      cnt     <= half_period - ONE;
      speaker <= 1'b0;
    end else if (run) begin
      if (cnt == '0) begin
        cnt     <= half_period - ONE;
        speaker <= ~speaker;
      end else begin
        cnt <= cnt - ONE;
      end
    end else begin
      speaker <= 1'b0;
    end
  end

endmodule

// File: rtl/key_tone_arbiter.sv
// Debounces light-sensor keys and grants one shared tone generator, lowest index wins, no preemption.
// Raw press to key_valid is 2+DEBOUNCE_CYC+2 clocks; release costs GAP_CYC silent clocks before re-arbitration.
module key_tone_arbiter
  import key_tone_pkg::*;
#(
  parameter int NUM_KEYS     = 8,
  parameter int DEBOUNCE_CYC = 3,
  parameter int GAP_CYC      = 2,
  parameter int CNT_W        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_in,
  input  logic                        enable,
  output logic                        speaker,
  output logic                        key_valid,
  output logic [$clog2(NUM_KEYS)-1:0] active_key
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  logic [NUM_KEYS-1:0] debounced;
  logic [NUM_KEYS-1:0] req;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic            sync1, sync2;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1        <= 1'b0;
        sync2        <= 1'b0;
        db_cnt       <= '0;
        debounced[i] <= 1'b0;
      end else begin
        sync1 <= key_in[i];
        sync2 <= sync1;
        if (sync2 != debounced[i]) begin
          if (db_cnt + DB_W'(1) == DB_W'(DEBOUNCE_CYC)) begin
            debounced[i] <= sync2;
            db_cnt       <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign req = debounced & {NUM_KEYS{enable}};

  state_t           state, state_nxt;
  logic [IDX_W-1:0] key_nxt, lowest;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             tone_load, tone_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      active_key <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      active_key <= key_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = active_key;
    gap_nxt   = gap_cnt;
    tone_load = 1'b0;
    tone_run  = 1'b0;
    lowest    = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (req[i]) lowest = IDX_W'(i);
    end
    case (state)
      IDLE: begin
        if (|req) begin
          key_nxt   = lowest;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tone_load = 1'b1;
        state_nxt = PLAY;
      end
      PLAY: begin
        // owner drop stops the tone on the same edge that enters GAP
        if (req[active_key]) begin
          tone_run = 1'b1;
        end else begin
          gap_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign key_valid = (state == PLAY);

  tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone (
    .clk        (clk),
    .rst        (rst),
    .load       (tone_load),
    .run        (tone_run),
    .half_period(CNT_W'(HALF_PERIOD[active_key])),
    .speaker    (speaker)
  );

endmodule
